// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised synchronous FIFO with status and sticky error flags
//
// Purpose:
//    Single-clock FIFO with any DEPTH >= 2 (not limited to powers of two).
//    The read port is combinational from storage, so a word written at one
//    edge is visible on rd_data in the next cycle.
//
// Optional feature:
//    PARAM_FIFO_ERR_FLAGS_EN - when defined, overflow/underflow are sticky
//    error flags cleared by err_clr. When undefined, both flags are tied to 0
//    and err_clr is ignored.
//
// Ports:
//    clk          - clock; all state changes on the rising edge
//    rst          - synchronous active-high reset
//    flush        - synchronous empty request (overrides wr/rd)
//    wr, wr_data  - write request and data
//    rd           - read request; pops the head entry
//    rd_data      - head entry, valid while empty=0
//    count        - current occupancy
//    full, empty, almost_full, almost_empty - status flags from registered count
//    overflow, underflow - sticky error flags
//    err_clr      - clears the error flags
module param_fifo #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 32,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         wr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         rd,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow,
   output logic                         underflow,
   input  logic                         err_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_en;
   logic                  rd_en;

   // A read while full frees a slot in the same cycle, so the write is accepted.
   assign wr_en = wr && (!full || rd);
   assign rd_en = rd && !empty;

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   assign rd_data = mem[rd_ptr];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   // Storage is deliberately not reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_en)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= ptr_next(wr_ptr);
         if (rd_en)
            rd_ptr <= ptr_next(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef PARAM_FIFO_ERR_FLAGS_EN
   logic ovf_set;
   logic unf_set;

   assign ovf_set = wr && full && !rd && !flush;
   assign unf_set = rd && empty && !flush;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set || (overflow  && !err_clr);
         underflow <= unf_set || (underflow && !err_clr);
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard testbench for param_fifo
module tb_param_fifo;

   localparam int DEPTH = 5;
   localparam int DW    = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          wr = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd = 1'b0;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] count;
   logic          full, empty, almost_full, almost_empty;
   logic          overflow, underflow;
   logic          err_clr = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] sb_q[$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   always #5 clk = ~clk;

   param_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(4), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr(wr), .wr_data(wr_data),
      .rd(rd), .rd_data(rd_data), .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, pop/compare scoreboard on reads, update
   // the reference model, then check all outputs after the edge.
   task automatic cyc(input bit w, input logic [DW-1:0] wd, input bit r,
                      input bit f, input bit c, input bit rs);
      int  sz;
      bit  w_ok, r_ok, ovf_set, unf_set;
      logic [DW-1:0] exp_d;
      rst = rs; flush = f; wr = w; wr_data = wd; rd = r; err_clr = c;
      sz      = sb_q.size();
      w_ok    = w && (sz < DEPTH || r);
      r_ok    = r && sz > 0;
      ovf_set = w && sz == DEPTH && !r && !f;
      unf_set = r && sz == 0 && !f;
      if (r_ok && !rs && !f) begin
         exp_d = sb_q.pop_front();
         check("rd_pop", rd_data, exp_d);
      end
      if (rs || f) begin
         sb_q.delete();
      end else if (w_ok) begin
         sb_q.push_back(wd);
      end
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      if (rs) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_ovf = ovf_set || (m_ovf && !c);
         m_unf = unf_set || (m_unf && !c);
      end
`else
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
      sz = sb_q.size();
      check("count", count, sz);
      check("full", full, sz == DEPTH);
      check("empty", empty, sz == 0);
      check("almost_full", almost_full, sz >= 4);
      check("almost_empty", almost_empty, sz <= 1);
      check("overflow", overflow, m_ovf);
      check("underflow", underflow, m_unf);
      if (sz > 0)
         check("rd_head", rd_data, sb_q[0]);
   endtask

   initial begin
      // reset
      cyc(0, 8'h00, 0, 0, 0, 1);

      // fill with A0..A4, then drain in order
      for (int i = 0; i < 5; i++) cyc(1, DW'(8'hA0 + i), 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);

      // pointer wrap: 4 rounds of 3 writes / 3 reads
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 3; i++) cyc(1, DW'(k * 3 + i + 1), 0, 0, 0, 0);
         for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0, 0);
      end

      // full: simultaneous wr/rd, then rejected write
      for (int i = 0; i < 5; i++) cyc(1, DW'(8'h10 + i), 0, 0, 0, 0);
      cyc(1, 8'hBB, 1, 0, 0, 0);
      cyc(1, 8'h55, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1, 0);

      // empty: simultaneous wr/rd accepts only the write
      cyc(1, 8'hCC, 1, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0, 0);
      // error raised in the same cycle as err_clr keeps the flag
      cyc(0, 8'h00, 1, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 1, 0);

      // flush with wr at count=3; flags persist through flush
      cyc(0, 8'h00, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, DW'(8'h30 + i), 0, 0, 0, 0);
      cyc(1, 8'h77, 0, 1, 0, 0);
      cyc(1, 8'h41, 0, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1, 0);

      // reset mid-operation with wr/rd and an active error flag
      cyc(0, 8'h00, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, DW'(8'h50 + i), 0, 0, 0, 0);
      cyc(1, 8'h99, 1, 0, 0, 1);
      cyc(1, 8'h61, 0, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of storage entries; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous empty request.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd  input  1  read request; pops the head entry.
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  head entry, combinational from storage, valid while empty=0.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags; err_clr  input  1  clears them.

Function
REQ-015 Accepted write (wr_en) SHALL be wr && (!full || rd); accepted read (rd_en) SHALL be rd && !empty.
REQ-016 Write pointer and read pointer SHALL each advance by 1 on their accept and wrap from DEPTH-1 to 0.
REQ-017 count SHALL be +1 on wr_en only, -1 on rd_en only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-018 full=(count==DEPTH); empty=(count==0); almost_full=(count>=AF_LEVEL); almost_empty=(count<=AE_LEVEL); all decoded from registered count.
REQ-019 Data written at edge N SHALL appear on rd_data, with empty=0, in the cycle after edge N (one-cycle write-to-read latency); no same-cycle bypass when empty.
REQ-020 wr and rd together while full SHALL perform both: head popped, new entry stored, count stays DEPTH.
REQ-021 wr and rd together while empty SHALL accept only the write; count becomes 1; the read counts as underflow.
REQ-022 flush SHALL zero both pointers and count at the next edge, overriding wr/rd in that cycle; storage contents and error flags unchanged.
REQ-023 overflow SHALL set when wr=1 and the write is rejected (full and rd=0); underflow SHALL set when rd=1 and empty=1; both ignored in a flush cycle.
REQ-024 Error flags SHALL hold until err_clr=1 at an edge; a new error in the same cycle as err_clr SHALL win (flag stays 1).

Reset
REQ-025 rst=1 at an edge SHALL set pointers=0, count=0, overflow=0, underflow=0, overriding flush, wr, rd, err_clr.
REQ-026 After reset outputs SHALL be empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>=1), count=0; rd_data undefined until first write.
REQ-027 Storage array SHALL NOT be reset; reset mid-operation discards all entries and any in-flight wr/rd of that cycle.

Configuration
REQ-028 Macro PARAM_FIFO_ERR_FLAGS_EN defined: overflow/underflow logic per REQ-023/024 compiled in.
REQ-029 Macro PARAM_FIFO_ERR_FLAGS_EN undefined: overflow and underflow SHALL be tied to 0, err_clr ignored; ports still present; all other behaviour identical.

Verification
REQ-030 DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: write 0xA0..0xA4 on 5 cycles -> count 1..5, almost_full=1 at count 4, full=1 at 5; read 5 times -> 0xA0..0xA4 in order, empty=1.
REQ-031 DEPTH=5: 3 writes, 3 reads, repeat 4 times with incrementing data -> pointers wrap past 4 to 0, every word read back in order, count returns to 0.
REQ-032 Full FIFO, wr=1 rd=1 with 0xBB -> head popped, count stays 5, 0xBB read out fifth; wr=1 rd=0 while full -> write dropped, overflow=1 (with macro).
REQ-033 Empty FIFO, wr=1 rd=1 with 0xCC -> count=1, rd_data=0xCC next cycle, underflow=1 (with macro), 0 without macro.
REQ-034 count=3, flush=1 with wr=1 -> count=0, empty=1 next cycle, write discarded, error flags unchanged; err_clr=1 -> flags 0.
REQ-035 count=3, rst=1 for one cycle with wr=1 rd=1 -> count=0, empty=1, overflow=underflow=0 after the edge.
